serial_alu: RTL and testbench

SERIAL_ALU -- requirements
Module: serial_alu

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_digit.sv | 38 +++
 rtl/serial_alu.sv | 145 ++++++++++++++
 tb/tb_serial_alu.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode definitions for the digit-serial ALU.
// Opcode type, opcode constants and a subtract-class helper.
package alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD  = 3'b000;
  localparam op_t OP_SUB  = 3'b001;
  localparam op_t OP_XOR  = 3'b010;
  localparam op_t OP_SLT  = 3'b011;
  localparam op_t OP_AND  = 3'b100;
  localparam op_t OP_NAND = 3'b101;
  localparam op_t OP_NOR  = 3'b110;
  localparam op_t OP_OR   = 3'b111;

  // SUB and SLT both add the inverted B with carry-in 1.
  function automatic logic is_sub(input op_t op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_digit.sv
// Combinational DIGIT-wide ALU slice used once per serial step.
// Produces the digit result, carry out and carry into the top bit.
module alu_digit
  import alu_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  op_t              s,
  input  logic             cin,
  output logic [DIGIT-1:0] y,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT-1:0] bb;
  logic [DIGIT:0]   sum;

  // Adder path plus bitwise ops, selected by opcode.
  always_comb begin
    bb   = is_sub(s) ? ~b : b;
    sum  = {1'b0, a} + {1'b0, bb}
         + {{DIGIT{1'b0}}, cin};
    cout = sum[DIGIT];
    cmsb = a[DIGIT-1] ^ bb[DIGIT-1]
         ^ sum[DIGIT-1];
    case (s)
      OP_XOR:  y = a ^ b;
      OP_AND:  y = a & b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_OR:   y = a | b;
      default: y = sum[DIGIT-1:0];
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Digit-serial ALU: WIDTH/DIGIT cycles per op, LSB digit first.
// Status flags are built only when SERIAL_ALU_FLAGS_EN is defined.
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       s,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] res_nx;
  op_t              s_r;
  logic             carry;
  logic [DIGIT-1:0] dy;
  logic             dcout;
  logic             dcmsb;
  logic             accept;
  logic             last;
  logic             lt;

  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_r[DIGIT-1:0]),
    .b    (b_r[DIGIT-1:0]),
    .s    (s_r),
    .cin  (carry),
    .y    (dy),
    .cout (dcout),
    .cmsb (dcmsb)
  );

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign accept = start
               && (state == IDLE || state == DONE);
  assign last   = (state == RUN)
               && (cnt == CW'(N - 1));

  // Shift the new digit in at the top; form the final result.
  always_comb begin
    acc_nx = acc >> DIGIT;
    acc_nx[WIDTH-1 -: DIGIT] = dy;
    lt     = acc_nx[WIDTH-1] ^ dcmsb ^ dcout;
    res_nx = (s_r == OP_SLT) ? WIDTH'(lt) : acc_nx;
  end

  // Control FSM, operand shifters and held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      s_r    <= OP_ADD;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state <= RUN;
            cnt   <= '0;
            a_r   <= a;
            b_r   <= b;
            s_r   <= s;
            carry <= is_sub(s);
            acc   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_r   <= a_r >> DIGIT;
          b_r   <= b_r >> DIGIT;
          acc   <= acc_nx;
          carry <= dcout;
          cnt   <= cnt + 1'b1;
          if (last) begin
            state  <= DONE;
            cnt    <= '0;
            result <= res_nx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ALU_FLAGS_EN
  logic cf_q;
  logic of_q;
  logic zf_q;
  logic arith;

  assign arith = (s_r == OP_ADD)
              || (s_r == OP_SUB);

  // Flags captured together with the final result.
  always_ff @(posedge clk) begin
    if (reset) begin
      cf_q <= 1'b0;
      of_q <= 1'b0;
      zf_q <= 1'b0;
    end else if (last) begin
      cf_q <= arith & dcout;
      of_q <= arith & (dcmsb ^ dcout);
      zf_q <= (res_nx == '0);
    end
  end

  assign carryout = cf_q;
  assign overflow = of_q;
  assign zero     = zf_q;
`else
  assign carryout = 1'b0;
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu (DIGIT=1 and DIGIT=4).
// Cycle model plus directed hand-computed vectors.
module tb_serial_alu;

`ifdef SERIAL_ALU_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       v;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start1 = 1'b0;
  logic [7:0] a1 = '0;
  logic [7:0] b1 = '0;
  logic [2:0] s1 = '0;
  logic       busy1, done1, cout1, ovf1, zero1;
  logic [7:0] result1;
  logic       start2 = 1'b0;
  logic [7:0] a2 = '0;
  logic [7:0] b2 = '0;
  logic [2:0] s2 = '0;
  logic       busy2, done2, cout2, ovf2, zero2;
  logic [7:0] result2;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_alu #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .a(a1), .b(b1), .s(s1),
    .busy(busy1), .done(done1), .result(result1),
    .carryout(cout1), .overflow(ovf1), .zero(zero1)
  );

  serial_alu #(.WIDTH(8), .DIGIT(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .a(a2), .b(b2), .s(s2),
    .busy(busy2), .done(done2), .result(result2),
    .carryout(cout2), .overflow(ovf2), .zero(zero2)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h",
                  nm, act, exp);
  endtask

  // Specification-level arithmetic for one 8-bit operation.
  function automatic exp_t model(input logic [7:0] a,
                                 input logic [7:0] b,
                                 input logic [2:0] s);
    exp_t e;
    logic [8:0] t;
    e = '0;
    t = '0;
    case (s)
      3'd0: begin
        t = {1'b0, a} + {1'b0, b};
        e.r = t[7:0];
        e.c = t[8];
        e.v = (a[7] == b[7]) && (e.r[7] != a[7]);
      end
      3'd1: begin
        t = {1'b0, a} + {1'b0, ~b} + 9'd1;
        e.r = t[7:0];
        e.c = t[8];
        e.v = (a[7] != b[7]) && (e.r[7] != a[7]);
      end
      3'd2: e.r = a ^ b;
      3'd3: e.r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      3'd4: e.r = a & b;
      3'd5: e.r = ~(a & b);
      3'd6: e.r = ~(a | b);
      default: e.r = a | b;
    endcase
    e.z = (e.r == 8'd0);
    return e;
  endfunction

  int   m1_left = 0;
  bit   m1_done = 0;
  exp_t m1_hold = '0;
  exp_t m1_pend = '0;
  int   m2_left = 0;
  bit   m2_done = 0;
  exp_t m2_hold = '0;
  exp_t m2_pend = '0;

  always @(posedge clk) begin
    if (reset) begin
      m1_left <= 0; m1_done <= 0; m1_hold <= '0;
    end else if (m1_left > 0) begin
      m1_left <= m1_left - 1;
      if (m1_left == 1) begin
        m1_done <= 1; m1_hold <= m1_pend;
      end
    end else begin
      m1_done <= 0;
      if (start1) begin
        m1_left <= 8;
        m1_pend <= model(a1, b1, s1);
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      m2_left <= 0; m2_done <= 0; m2_hold <= '0;
    end else if (m2_left > 0) begin
      m2_left <= m2_left - 1;
      if (m2_left == 1) begin
        m2_done <= 1; m2_hold <= m2_pend;
      end
    end else begin
      m2_done <= 0;
      if (start2) begin
        m2_left <= 2;
        m2_pend <= model(a2, b2, s2);
      end
    end
  end

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    chk("busy1", busy1, m1_left > 0);
    chk("done1", done1, m1_done);
    chk("result1", result1, m1_hold.r);
    chk("cout1", cout1, FL & m1_hold.c);
    chk("ovf1", ovf1, FL & m1_hold.v);
    chk("zero1", zero1, FL & m1_hold.z);
    chk("busy2", busy2, m2_left > 0);
    chk("done2", done2, m2_done);
    chk("result2", result2, m2_hold.r);
    chk("cout2", cout2, FL & m2_hold.c);
    chk("ovf2", ovf2, FL & m2_hold.v);
    chk("zero2", zero2, FL & m2_hold.z);
  end

  // Run one op on dut1; returns negedges from accept to done.
  task automatic op1(input logic [7:0] a,
                     input logic [7:0] b,
                     input logic [2:0] s,
                     output int lat);
    @(negedge clk);
    a1 = a; b1 = b; s1 = s; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done1 && lat < 40);
    if (lat >= 40) chk("timeout1", lat, 0);
  endtask

  int   lat;
  int   cnt;
  exp_t e;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_result", result1, 8'h00);
    reset = 1'b0;

    e = model(8'h7F, 8'h01, 3'd0);
    chk("model_add_r", e.r, 8'h80);
    chk("model_add_v", e.v, 1);
    e = model(8'h07, 8'h07, 3'd1);
    chk("model_sub_c", e.c, 1);
    e = model(8'h80, 8'h7F, 3'd3);
    chk("model_slt", e.r, 8'h01);

    op1(8'h7F, 8'h01, 3'd0, lat);
    chk("add_latency", lat, 9);
    chk("add_r", result1, 8'h80);
    chk("add_v", ovf1, FL);
    chk("add_c", cout1, 0);
    chk("add_z", zero1, 0);

    op1(8'h05, 8'h07, 3'd1, lat);
    chk("sub_r", result1, 8'hFE);
    chk("sub_c", cout1, 0);
    chk("sub_v", ovf1, 0);
    op1(8'h07, 8'h07, 3'd1, lat);
    chk("sub0_r", result1, 8'h00);
    chk("sub0_z", zero1, FL);
    chk("sub0_c", cout1, FL);

    op1(8'hFF, 8'h01, 3'd3, lat);
    chk("slt_a", result1, 8'h01);
    op1(8'h01, 8'hFF, 3'd3, lat);
    chk("slt_b", result1, 8'h00);
    op1(8'h80, 8'h7F, 3'd3, lat);
    chk("slt_c", result1, 8'h01);
    chk("slt_v", ovf1, 0);

    op1(8'hF0, 8'hFF, 3'd5, lat);
    chk("nand", result1, 8'h0F);
    op1(8'h00, 8'h00, 3'd6, lat);
    chk("nor", result1, 8'hFF);
    op1(8'hA5, 8'hA5, 3'd2, lat);
    chk("xor", result1, 8'h00);
    chk("xor_z", zero1, FL);

    // start during RUN is ignored
    @(negedge clk);
    a1 = 8'h03; b1 = 8'h04; s1 = 3'd0; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (3) @(negedge clk);
    a1 = 8'hFF; b1 = 8'hFF; s1 = 3'd7; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cnt = 0;
    while (!done1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("ignore_done", done1, 1);
    chk("ignore_r", result1, 8'h07);

    // reset mid-RUN discards the op
    op1(8'h11, 8'h22, 3'd0, lat);
    @(negedge clk);
    a1 = 8'h10; b1 = 8'h20; s1 = 3'd0; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_busy", busy1, 0);
    chk("mrst_result", result1, 8'h00);
    chk("mrst_done", done1, 0);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done1) cnt++;
    end
    chk("mrst_nodone", cnt, 0);

    // DIGIT=4: two busy cycles, back-to-back start
    @(negedge clk);
    a2 = 8'h0F; b2 = 8'h01; s2 = 3'd0; start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    cnt = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy2) cnt++;
    end while (!done2 && lat < 40);
    chk("d4_busy", cnt, 2);
    chk("d4_r", result2, 8'h10);
    a2 = 8'h21; b2 = 8'h01; s2 = 3'd0; start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    @(negedge clk);
    chk("b2b_busy", busy2, 1);
    chk("b2b_hold", result2, 8'h10);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done", done2, 1);
    chk("b2b_r", result2, 8'h22);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
